// File: rtl/mytimer2.sv
// Programmable interval timer: prescaled down-counter with one-shot/auto-reload,
// sticky timeout flag and maskable level interrupt on a simple CPU slave port.
module mytimer2 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PRE_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        irq,
  input  logic        s_cs_n,
  input  logic [2:0]  s_address,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        s_write,
  input  logic [31:0] s_writedata
);

  localparam logic [2:0] AddrControl  = 3'd0;
  localparam logic [2:0] AddrPeriod   = 3'd1;
  localparam logic [2:0] AddrCount    = 3'd2;
  localparam logic [2:0] AddrStatus   = 3'd3;
  localparam logic [2:0] AddrPrescale = 3'd4;

  logic                 en_q, en_d;
  logic                 cont_q, cont_d;
  logic                 ie_q, ie_d;
  logic                 to_q, to_d;
  logic [WIDTH-1:0]     period_q, period_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [PRE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [31:0]          rdata_q, rdata_d;

  logic wr, rd;
  logic ctrl_wr, period_wr, count_wr, status_wr, prescale_wr;
  logic start, stop, tick, timeout;

  assign wr          = ~s_cs_n & s_write;
  assign rd          = ~s_cs_n & s_read;
  assign ctrl_wr     = wr && (s_address == AddrControl);
  assign period_wr   = wr && (s_address == AddrPeriod);
  assign count_wr    = wr && (s_address == AddrCount);
  assign status_wr   = wr && (s_address == AddrStatus);
  assign prescale_wr = wr && (s_address == AddrPrescale);

  assign start = ctrl_wr && s_writedata[0] && !en_q;
  assign stop  = ctrl_wr && !s_writedata[0];

  // >= rather than == so a PRESCALE shrunk below pre_cnt mid-run ticks at once
  // instead of wrapping the whole prescaler range.
  assign tick    = en_q && (pre_cnt_q >= prescale_q);
  assign timeout = tick && (count_q == '0);

  always_comb begin
    en_d       = en_q;
    cont_d     = cont_q;
    ie_d       = ie_q;
    to_d       = to_q;
    period_d   = period_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;

    if (en_q) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_WIDTH'(1);
    end else begin
      pre_cnt_d = '0;
    end

    // A stopping write freezes COUNT on its own edge; the timeout flag still lands.
    if (tick && !stop) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else if (cont_q) begin
        count_d = period_q;
      end
    end

    if (timeout && !cont_q) begin
      en_d = 1'b0;
    end

    if (ctrl_wr) begin
      en_d   = s_writedata[0];
      cont_d = s_writedata[1];
      ie_d   = s_writedata[2];
      if (start || stop) begin
        pre_cnt_d = '0;
      end
    end
    if (start) begin
      count_d = period_q;
    end

    if (period_wr) begin
      period_d = s_writedata[WIDTH-1:0];
    end
    if (count_wr) begin
      count_d = s_writedata[WIDTH-1:0];
    end
    if (prescale_wr) begin
      prescale_d = s_writedata[PRE_WIDTH-1:0];
    end

    // Set beats clear so a timeout coinciding with the acknowledge is not lost.
    if (status_wr && s_writedata[0]) begin
      to_d = 1'b0;
    end
    if (timeout) begin
      to_d = 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      case (s_address)
        AddrControl:  rdata_d[2:0]           = {ie_q, cont_q, en_q};
        AddrPeriod:   rdata_d[WIDTH-1:0]     = period_q;
        AddrCount:    rdata_d[WIDTH-1:0]     = count_q;
        AddrStatus:   rdata_d[1:0]           = {en_q, to_q};
        AddrPrescale: rdata_d[PRE_WIDTH-1:0] = prescale_q;
        default:      rdata_d                = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      cont_q     <= 1'b0;
      ie_q       <= 1'b0;
      to_q       <= 1'b0;
      period_q   <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      rdata_q    <= '0;
    end else begin
      en_q       <= en_d;
      cont_q     <= cont_d;
      ie_q       <= ie_d;
      to_q       <= to_d;
      period_q   <= period_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign irq        = to_q & ie_q;
  assign s_readdata = rdata_q;

endmodule

// File: tb/tb_mytimer2.sv
// Directed bench for mytimer2: a default-width instance plus an 8-bit instance for
// truncation and unmapped-address behaviour.
module tb_mytimer2;

  logic        clk;
  logic        reset_n;
  logic        cs_n, cs8_n;
  logic [2:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata8;
  logic        irq, irq8;

  int checks   = 0;
  int failures = 0;

  mytimer2 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq         (irq),
    .s_cs_n      (cs_n),
    .s_address   (addr),
    .s_read      (rd),
    .s_readdata  (rdata),
    .s_write     (wr),
    .s_writedata (wdata)
  );

  mytimer2 #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .irq         (irq8),
    .s_cs_n      (cs8_n),
    .s_address   (addr),
    .s_read      (rd),
    .s_readdata  (rdata8),
    .s_write     (wr),
    .s_writedata (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered at a negedge and return at the following negedge.
  task automatic bus_write(input bit w8, input logic [2:0] a, input logic [31:0] d);
    if (w8) cs8_n = 1'b0; else cs_n = 1'b0;
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs_n = 1'b1; cs8_n = 1'b1; wr = 1'b0;
  endtask

  task automatic bus_read(input bit w8, input logic [2:0] a, output logic [31:0] d);
    if (w8) cs8_n = 1'b0; else cs_n = 1'b0;
    rd = 1'b1; addr = a;
    @(negedge clk);
    cs_n = 1'b1; cs8_n = 1'b1; rd = 1'b0;
    d = w8 ? rdata8 : rdata;
  endtask

  task automatic chk_reg(input bit w8, input logic [2:0] a, input logic [31:0] exp,
                         input string tag);
    logic [31:0] d;
    bus_read(w8, a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;

  initial begin
    reset_n = 1'b0; cs_n = 1'b1; cs8_n = 1'b1; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 5; a++) chk_reg(0, 3'(a), 32'h0, "reset_reg");
    check("reset_irq", {31'b0, irq}, 32'h0);

    bus_write(0, 3'd4, 32'h0001_2345);
    chk_reg(0, 3'd4, 32'h0000_2345, "prescale_trunc");

    // One-shot, PRESCALE=0, PERIOD=4
    bus_write(0, 3'd4, 32'h0);
    bus_write(0, 3'd1, 32'd4);
    bus_write(0, 3'd0, 32'h5);
    chk_reg(0, 3'd2, 32'd4, "oneshot_cnt4");
    chk_reg(0, 3'd2, 32'd3, "oneshot_cnt3");
    chk_reg(0, 3'd2, 32'd2, "oneshot_cnt2");
    chk_reg(0, 3'd2, 32'd1, "oneshot_cnt1");
    check("oneshot_irq_pre", {31'b0, irq}, 32'h0);
    chk_reg(0, 3'd2, 32'd0, "oneshot_cnt0");
    check("oneshot_irq", {31'b0, irq}, 32'h1);
    chk_reg(0, 3'd3, 32'h1, "oneshot_status");
    chk_reg(0, 3'd2, 32'd0, "oneshot_hold0");
    chk_reg(0, 3'd0, 32'h4, "oneshot_ctrl");
    bus_write(0, 3'd3, 32'h1);
    check("oneshot_irq_clr", {31'b0, irq}, 32'h0);

    // Auto-reload, PRESCALE=2, PERIOD=9: timeouts every 30 cycles
    bus_write(0, 3'd4, 32'd2);
    bus_write(0, 3'd1, 32'd9);
    bus_write(0, 3'd0, 32'h7);
    wait_irq(n);
    check("reload_first", n, 32'd30);
    bus_write(0, 3'd3, 32'h1);
    check("reload_irq_drop", {31'b0, irq}, 32'h0);
    wait_irq(n);
    check("reload_interval", n + 1, 32'd30);

    // Clear landing exactly on the third timeout edge
    bus_write(0, 3'd3, 32'h1);
    check("coll_irq_clr", {31'b0, irq}, 32'h0);
    repeat (28) @(negedge clk);
    check("coll_irq_pre", {31'b0, irq}, 32'h0);
    bus_write(0, 3'd3, 32'h1);
    check("coll_irq", {31'b0, irq}, 32'h1);
    chk_reg(0, 3'd3, 32'h3, "coll_status");

    // Stop at 57, hold, restart
    bus_write(0, 3'd0, 32'h0);
    bus_write(0, 3'd3, 32'h1);
    bus_write(0, 3'd4, 32'h0);
    bus_write(0, 3'd1, 32'd100);
    bus_write(0, 3'd0, 32'h1);
    repeat (43) @(negedge clk);
    bus_write(0, 3'd0, 32'h0);
    repeat (20) @(negedge clk);
    chk_reg(0, 3'd2, 32'd57, "stop_hold57");
    chk_reg(0, 3'd3, 32'h0, "stop_status");
    bus_write(0, 3'd0, 32'h1);
    chk_reg(0, 3'd2, 32'd100, "restart_load");
    bus_write(0, 3'd1, 32'd5);
    chk_reg(0, 3'd2, 32'd98, "period_no_effect");
    bus_write(0, 3'd2, 32'd50);
    chk_reg(0, 3'd2, 32'd50, "count_wr_wins");
    bus_write(0, 3'd0, 32'h3);
    bus_write(0, 3'd2, 32'd0);
    @(negedge clk);
    chk_reg(0, 3'd2, 32'd5, "reload_new_period");
    chk_reg(0, 3'd3, 32'h3, "reload_status");

    // Narrow instance: truncation and unmapped addresses
    bus_write(1, 3'd1, 32'h1FF);
    chk_reg(1, 3'd1, 32'hFF, "w8_period_trunc");
    chk_reg(1, 3'd6, 32'h0, "w8_addr6");
    bus_write(1, 3'd7, 32'hFFFF_FFFF);
    chk_reg(1, 3'd0, 32'h0, "w8_a7_ctrl");
    chk_reg(1, 3'd1, 32'hFF, "w8_a7_period");
    chk_reg(1, 3'd2, 32'h0, "w8_a7_count");
    chk_reg(1, 3'd3, 32'h0, "w8_a7_status");
    chk_reg(1, 3'd4, 32'h0, "w8_a7_prescale");

    // Reset mid-run
    bus_write(0, 3'd0, 32'h7);
    check("prereset_irq", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a < 5; a++) chk_reg(0, 3'(a), 32'h0, "midreset_reg");
    repeat (10) @(negedge clk);
    chk_reg(0, 3'd2, 32'h0, "midreset_stays");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
